deserializer: RTL

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/bus_pkg.sv | 29 ++
 rtl/sclk_sync.sv | 39 +++
 rtl/deserializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: frame layout, command encoding and parity rule.
package bus_pkg;

  localparam int FRAME_WIDTH = 27;

  typedef enum logic [1:0] {
    CMD_WRITE          = 2'd0,
    CMD_READ           = 2'd1,
    CMD_SPLIT_START    = 2'd2,
    CMD_SPLIT_CONTINUE = 2'd3
  } cmd_e;

  // Sent MSB first: start bit leads, stop bit trails.
  typedef struct packed {
    logic       start;
    cmd_e       cmd;
    logic [13:0] addr;
    logic [7:0] data;
    logic       parity;
    logic       stop;
  } serial_frame_t;

  // Even parity over the payload fields.
  function automatic logic calc_parity(input cmd_e cmd, input logic [13:0] addr,
                                       input logic [7:0] data);
    return ^{cmd, addr, data};
  endfunction

endpackage

// File: rtl/sclk_sync.sv
// Two-flop synchronizer for the serial clock and data, plus registered
// rising-edge detection of the synchronized serial clock.
module sclk_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic sdata,
  output logic bit_event,
  output logic bit_value
);

  logic sclk_s1;
  logic sclk_s2;
  logic sclk_prev;
  logic sdata_s1;
  logic sdata_s2;

  // Sync both lines, remember the last sclk sample and flag a 0->1 transition with its data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      sdata_s1  <= 1'b0;
      sdata_s2  <= 1'b0;
      bit_event <= 1'b0;
      bit_value <= 1'b0;
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sdata_s1  <= sdata;
      sdata_s2  <= sdata_s1;
      bit_event <= sclk_s2 & ~sclk_prev;
      bit_value <= sdata_s2;
    end
  end

endmodule

// File: rtl/deserializer.sv
// Serial frame receiver: collects start..stop bits MSB first, then checks the
// stop bit and parity and publishes clean frames. Stalled frames are aborted.
module deserializer
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sdata_i,
  input  logic          sclk_i,
  output serial_frame_t frame_o,
  output logic          valid_o,
  output logic          parity_err_o,
  output logic          frame_err_o,
  output logic          busy_o
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

  state_e                 state;
  state_e                 state_next;
  logic [FRAME_WIDTH-1:0] shift;
  logic [FRAME_WIDTH-1:0] shift_next;
  logic [4:0]             bit_cnt;
  logic [4:0]             bit_cnt_next;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [IDLE_W-1:0]      idle_cnt_next;
  serial_frame_t          frame_next;
  logic                   valid_next;
  logic                   parity_err_next;
  logic                   frame_err_next;
  logic                   bit_event;
  logic                   bit_value;
  serial_frame_t          rx;

  sclk_sync u_sclk_sync (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .sclk      (sclk_i),
    .sdata     (sdata_i),
    .bit_event (bit_event),
    .bit_value (bit_value)
  );

  assign rx     = serial_frame_t'(shift);
  assign busy_o = (state != IDLE);

  // Next-state, shift/count updates and the one-cycle result pulses.
  always_comb begin
    state_next      = state;
    shift_next      = shift;
    bit_cnt_next    = bit_cnt;
    idle_cnt_next   = idle_cnt;
    frame_next      = frame_o;
    valid_next      = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bit_event && bit_value) begin
          state_next    = RECV;
          shift_next    = {{(FRAME_WIDTH-1){1'b0}}, 1'b1};
          bit_cnt_next  = 5'd1;
          idle_cnt_next = '0;
        end
      end
      RECV: begin
        if (bit_event) begin
          shift_next    = {shift[FRAME_WIDTH-2:0], bit_value};
          idle_cnt_next = '0;
          if (bit_cnt < 5'(FRAME_WIDTH)) begin
            bit_cnt_next = bit_cnt + 5'd1;
          end
          if (bit_cnt == 5'(FRAME_WIDTH - 1)) begin
            state_next = CHECK;
          end
        end else if (idle_cnt >= IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
          shift_next     = '0;
          bit_cnt_next   = '0;
          idle_cnt_next  = '0;
        end else begin
          idle_cnt_next = idle_cnt + 1'b1;
        end
      end
      CHECK: begin
        state_next    = IDLE;
        bit_cnt_next  = '0;
        idle_cnt_next = '0;
        if (!rx.stop || !rx.start) begin
          frame_err_next = 1'b1;
        end else if (rx.parity != calc_parity(rx.cmd, rx.addr, rx.data)) begin
          parity_err_next = 1'b1;
        end else begin
          valid_next = 1'b1;
          frame_next = rx;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift        <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      frame_o      <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      shift        <= shift_next;
      bit_cnt      <= bit_cnt_next;
      idle_cnt     <= idle_cnt_next;
      frame_o      <= frame_next;
      valid_o      <= valid_next;
      parity_err_o <= parity_err_next;
      frame_err_o  <= frame_err_next;
    end
  end

endmodule
